// File: rtl/mem_pkg.sv
// Shared types and constants for the memory responder and its RAM.
package mem_pkg;

    localparam int unsigned ADDR_BUS_W      = 32;
    localparam int unsigned WAITCNT_W       = 4;
    localparam int unsigned WAIT_CYCLES_DEF = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

    // True when any address bit above the RAM window is set.
    function automatic logic addr_oor(input logic [ADDR_BUS_W-1:0] a, input int unsigned aw);
        return (a >> aw) != '0;
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bus between the MAR/MDR memory subsystem and the responder.
interface mem_responder_if #(
    parameter int unsigned DATA_W = 32
);
    import mem_pkg::*;

    logic [ADDR_BUS_W-1:0] addr;
    logic [DATA_W-1:0]     wdata;
    logic                  memRead;
    logic                  memWrite;
    logic [DATA_W-1:0]     MDatain;
    logic                  memDone;
    logic                  memErr;
    logic                  busy;

    modport master (
        output addr, wdata, memRead, memWrite,
        input  MDatain, memDone, memErr, busy
    );

    modport slave (
        input  addr, wdata, memRead, memWrite,
        output MDatain, memDone, memErr, busy
    );

endinterface

// File: rtl/ram_array.sv
// Single-port synchronous RAM with registered read data; no reset on contents.
module ram_array #(
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: four-phase req/done handshake, programmable wait
// states, range checking, and a single-port RAM behind it.
module mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W      = 9,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEF
) (
    input  logic            clk,
    input  logic            clr,
    mem_responder_if.slave  bus
);

    state_t                 state;
    op_t                    op_q;
    logic [ADDR_BUS_W-1:0]  addr_q;
    logic [DATA_W-1:0]      wdata_q;
    logic [WAITCNT_W-1:0]   cnt;
    logic [DATA_W-1:0]      md_q;
    logic                   done_q;
    logic                   err_q;
    logic                   busy_q;

    logic                   req_held_c;
    logic                   oor_c;
    logic                   access_c;
    logic                   ram_we_c;
    logic [ADDR_W-1:0]      ram_addr_c;
    logic [DATA_W-1:0]      ram_rdata;

    assign req_held_c = (op_q == OP_WRITE) ? bus.memWrite : bus.memRead;
    assign oor_c      = addr_oor(addr_q, ADDR_W);
    assign access_c   = (state == BUSY) && req_held_c && (cnt == '0);
    assign ram_we_c   = access_c && (op_q == OP_WRITE) && !oor_c && !clr;

    // Look up the live address while idle so read data is ready even with zero wait states.
    assign ram_addr_c = (state == IDLE) ? bus.addr[ADDR_W-1:0] : addr_q[ADDR_W-1:0];

    ram_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we_c),
        .addr  (ram_addr_c),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            state  <= IDLE;
            md_q   <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            busy_q <= 1'b0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.memRead && bus.memWrite) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                        err_q  <= 1'b1;
                    end else if (bus.memRead || bus.memWrite) begin
                        addr_q  <= bus.addr;
                        wdata_q <= bus.wdata;
                        op_q    <= bus.memWrite ? OP_WRITE : OP_READ;
                        cnt     <= WAITCNT_W'(WAIT_CYCLES);
                        state   <= BUSY;
                        busy_q  <= 1'b1;
                    end
                end
                BUSY: begin
                    if (!req_held_c) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else if (cnt != '0) begin
                        cnt <= cnt - WAITCNT_W'(1);
                    end else begin
                        state  <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        err_q  <= oor_c;
                        if (op_q == OP_READ) begin
                            md_q <= oor_c ? '0 : ram_rdata;
                        end
                    end
                end
                DONE: begin
                    // Hold completion until the requester releases both lines.
                    if (!bus.memRead && !bus.memWrite) begin
                        state  <= IDLE;
                        done_q <= 1'b0;
                        err_q  <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    err_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.MDatain = md_q;
    assign bus.memDone = done_q;
    assign bus.memErr  = err_q;
    assign bus.busy    = busy_q;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench: two responders (WAIT_CYCLES=2 and 0) driven by directed
// vectors, handshake corner cases, and random traffic against a memory model.
module tb_mem_responder;

    logic clk = 1'b0;
    logic clr;
    always #5 clk = ~clk;

    mem_responder_if #(.DATA_W(32)) if2 ();
    mem_responder_if #(.DATA_W(32)) if0 ();

    mem_responder #(.ADDR_W(9), .DATA_W(32), .WAIT_CYCLES(2)) dut2 (
        .clk (clk), .clr (clr), .bus (if2)
    );
    mem_responder #(.ADDR_W(9), .DATA_W(32), .WAIT_CYCLES(0)) dut0 (
        .clk (clk), .clr (clr), .bus (if0)
    );

    typedef struct {
        logic        done;
        logic        err;
        logic        busy;
        logic [31:0] md;
    } obs_t;

    typedef struct {
        bit          rd;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          exp_err;
        logic [31:0] exp_md;
        string       name;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: word array and last MDatain, one per DUT (index 1 = zero-wait DUT).
    logic [31:0] model   [2][512];
    logic [31:0] last_md [2];
    logic [31:0] pool    [16];
    vec_t        vecs    [5];

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input bit w0, input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
        if (w0) begin
            if0.memRead = rd; if0.memWrite = wr; if0.addr = a; if0.wdata = d;
        end else begin
            if2.memRead = rd; if2.memWrite = wr; if2.addr = a; if2.wdata = d;
        end
    endtask

    task automatic set_wdata(input bit w0, input logic [31:0] d);
        if (w0) if0.wdata = d;
        else    if2.wdata = d;
    endtask

    function automatic obs_t sample(input bit w0);
        obs_t o;
        if (w0) begin
            o.done = if0.memDone; o.err = if0.memErr; o.busy = if0.busy; o.md = if0.MDatain;
        end else begin
            o.done = if2.memDone; o.err = if2.memErr; o.busy = if2.busy; o.md = if2.MDatain;
        end
        return o;
    endfunction

    // Expected outcome of one handshake, straight from the protocol rules.
    function automatic void predict(input bit w0, input bit rd, input bit wr, input logic [31:0] a,
                                    input logic [31:0] d, output bit err, output logic [31:0] md);
        int i;
        bit oor;
        i   = w0 ? 1 : 0;
        oor = (a >= 32'd512);
        if (rd && wr) begin
            err = 1'b1;
        end else if (oor) begin
            err = 1'b1;
            if (rd) last_md[i] = 32'h0;
        end else begin
            err = 1'b0;
            if (rd) last_md[i] = model[i][a[8:0]];
            else    model[i][a[8:0]] = d;
        end
        md = last_md[i];
    endfunction

    // Caller is positioned just after a falling edge; returns likewise, with the DUT back in IDLE.
    task automatic do_txn(input bit w0, input bit rd, input bit wr, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] d_after, input int hold,
                          input bit exp_err, input logic [31:0] exp_md, input string name);
        int   k;
        int   exp_k;
        bit   done;
        bit   busy_ok;
        bit   held_ok;
        obs_t o;
        exp_k   = (rd && wr) ? 1 : (w0 ? 2 : 4);
        k       = 0;
        done    = 1'b0;
        busy_ok = 1'b1;
        drive(w0, rd, wr, a, d);
        while (!done && k < 40) begin
            @(negedge clk);
            k++;
            if (k == 1) set_wdata(w0, d_after);
            o = sample(w0);
            if (o.busy !== (k < exp_k)) busy_ok = 1'b0;
            if (o.done === 1'b1) done = 1'b1;
        end
        check(done && k == exp_k, {name, " latency"}, 32'(k), 32'(exp_k));
        check(o.err === exp_err, {name, " memErr"}, 32'(o.err), 32'(exp_err));
        check(o.md === exp_md, {name, " MDatain"}, o.md, exp_md);
        check(busy_ok, {name, " busy"}, 32'(o.busy), 32'(0));
        held_ok = 1'b1;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            o = sample(w0);
            if (o.done !== 1'b1 || o.err !== exp_err || o.md !== exp_md) held_ok = 1'b0;
        end
        if (hold > 0) check(held_ok, {name, " hold"}, 32'(o.done), 32'(1));
        drive(w0, 1'b0, 1'b0, a, d_after);
        @(negedge clk);
        o = sample(w0);
        check(o.done === 1'b0 && o.err === 1'b0 && o.busy === 1'b0, {name, " release"},
              {29'h0, o.busy, o.err, o.done}, 32'h0);
    endtask

    // Predict, then run the handshake against the prediction.
    task automatic txn(input bit w0, input bit rd, input bit wr, input logic [31:0] a,
                       input logic [31:0] d, input int hold, input string name);
        bit          e;
        logic [31:0] m;
        predict(w0, rd, wr, a, d, e, m);
        do_txn(w0, rd, wr, a, d, d, hold, e, m, name);
    endtask

    initial begin
        obs_t        o;
        bit          e;
        bit          ok;
        logic [31:0] m;

        vecs[0] = '{1'b0, 1'b1, 32'h10,  32'hDEADBEEF, 1'b0, 32'h0,        "wr_0x10"};
        vecs[1] = '{1'b1, 1'b0, 32'h10,  32'h0,        1'b0, 32'hDEADBEEF, "rd_0x10"};
        vecs[2] = '{1'b1, 1'b0, 32'h200, 32'h0,        1'b1, 32'h0,        "rd_oor"};
        vecs[3] = '{1'b1, 1'b1, 32'h10,  32'h12345678, 1'b1, 32'h0,        "rd_wr_both"};
        vecs[4] = '{1'b1, 1'b0, 32'h10,  32'h0,        1'b0, 32'hDEADBEEF, "rd_0x10_again"};
        for (int i = 0; i < 16; i++) pool[i] = 32'h100 + 32'(i * 7);
        last_md[0] = 32'h0;
        last_md[1] = 32'h0;

        clr = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (3) @(negedge clk);
        for (int w = 0; w < 2; w++) begin
            o = sample(w[0]);
            check(o.done === 1'b0, "reset memDone", 32'(o.done), 32'h0);
            check(o.err  === 1'b0, "reset memErr",  32'(o.err),  32'h0);
            check(o.busy === 1'b0, "reset busy",    32'(o.busy), 32'h0);
            check(o.md   === 32'h0, "reset MDatain", o.md, 32'h0);
        end
        clr = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            predict(1'b0, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, e, m);
            do_txn(1'b0, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].wdata,
                   1, vecs[i].exp_err, vecs[i].exp_md, vecs[i].name);
        end

        // Held write: data changes after acceptance and the line stays high long after memDone.
        predict(1'b0, 1'b0, 1'b1, 32'h20, 32'h1, e, m);
        do_txn(1'b0, 1'b0, 1'b1, 32'h20, 32'h1, 32'h2, 8, 1'b0, 32'hDEADBEEF, "held_wr");
        do_txn(1'b0, 1'b1, 1'b0, 32'h20, 32'h0, 32'h0, 0, 1'b0, 32'h1, "held_rd");
        last_md[0] = 32'h1;

        txn(1'b0, 1'b0, 1'b1, 32'h30, 32'h0,  0, "init_0x30");
        txn(1'b0, 1'b0, 1'b1, 32'h40, 32'h77, 0, "init_0x40");

        // Abort in the first BUSY cycle.
        drive(1'b0, 1'b0, 1'b1, 32'h30, 32'h55);
        @(negedge clk);
        o = sample(1'b0);
        check(o.busy === 1'b1, "abort busy", 32'(o.busy), 32'h1);
        drive(1'b0, 1'b0, 1'b0, 32'h30, 32'h55);
        ok = 1'b1;
        repeat (6) begin
            @(negedge clk);
            o = sample(1'b0);
            if (o.done !== 1'b0) ok = 1'b0;
        end
        check(ok, "abort memDone", 32'(o.done), 32'h0);
        check(o.busy === 1'b0 && o.md === 32'h1, "abort idle", o.md, 32'h1);
        do_txn(1'b0, 1'b1, 1'b0, 32'h30, 32'h0, 32'h0, 0, 1'b0, 32'h0, "abort_rd");
        last_md[0] = 32'h0;
        txn(1'b0, 1'b1, 1'b0, 32'h40, 32'h0, 0, "pre_clr_rd");

        // Reset while a write is in flight.
        drive(1'b0, 1'b0, 1'b1, 32'h40, 32'h99);
        @(negedge clk);
        o = sample(1'b0);
        check(o.busy === 1'b1, "clr busy before", 32'(o.busy), 32'h1);
        clr = 1'b1;
        @(negedge clk);
        o = sample(1'b0);
        check(o.done === 1'b0 && o.err === 1'b0 && o.busy === 1'b0 && o.md === 32'h0,
              "clr outputs", o.md, 32'h0);
        clr = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h40, 32'h99);
        last_md[0] = 32'h0;
        last_md[1] = 32'h0;
        repeat (4) @(negedge clk);
        o = sample(1'b0);
        check(o.done === 1'b0 && o.busy === 1'b0, "clr stays idle", 32'(o.done), 32'h0);
        do_txn(1'b0, 1'b1, 1'b0, 32'h40, 32'h0, 32'h0, 0, 1'b0, 32'h77, "clr_rd_0x40");
        last_md[0] = 32'h77;

        // Zero wait states: back-to-back reads with the minimum idle gap.
        txn(1'b1, 1'b0, 1'b1, 32'h1, 32'hA1A1A1A1, 0, "w0_wr_1");
        txn(1'b1, 1'b0, 1'b1, 32'h2, 32'hB2B2B2B2, 0, "w0_wr_2");
        do_txn(1'b1, 1'b1, 1'b0, 32'h1, 32'h0, 32'h0, 0, 1'b0, 32'hA1A1A1A1, "w0_rd_1");
        do_txn(1'b1, 1'b1, 1'b0, 32'h2, 32'h0, 32'h0, 0, 1'b0, 32'hB2B2B2B2, "w0_rd_2");
        last_md[1] = 32'hB2B2B2B2;

        // Random traffic over a small address pool so reads hit earlier writes.
        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < 16; i++) txn(w[0], 1'b0, 1'b1, pool[i], $urandom, 0, "pool_init");
            for (int i = 0; i < 50; i++) begin
                int          r;
                bit          rd;
                bit          wr;
                logic [31:0] a;
                logic [31:0] d;
                logic [31:0] d2;
                r  = int'($urandom_range(0, 99));
                rd = (r < 50) || (r >= 94);
                wr = (r >= 50);
                a  = pool[$urandom_range(0, 15)];
                if ($urandom_range(0, 9) == 0) a = a | (32'h200 << $urandom_range(0, 22));
                d  = $urandom;
                d2 = $urandom;
                predict(w[0], rd, wr, a, d, e, m);
                do_txn(w[0], rd, wr, a, d, d2, int'($urandom_range(0, 3)), e, m, "rand");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
